// File: rtl/conv_pixel_packer.sv
// conv_pixel_packer
//   Last stage of the 3x3 convolution datapath. Gathers 4-bit conv results,
//   packs three per 12-bit word as {p0,p1,p2} (p0 in [11:8]) and writes the
//   words to the output frame RAM. The last word of each line is padded with
//   zeros in its unfilled low nibbles. Signals frame completion with a pulse
//   aligned to the final write.
//
// Parameters
//   IMG_W   output pixels per line
//   IMG_H   output lines per frame
//   ADDR_W  word address width, must hold IMG_H*ceil(IMG_W/3)
//
// Ports
//   pixel_clk    clock, rising edge
//   rst          asynchronous active-high reset
//   start        1-cycle pulse, begins a frame (honoured in IDLE only)
//   pix_valid    pix_in carries a new conv result
//   pix_in       conv result 0..15
//   wr_en        RAM write strobe, one cycle per word
//   wr_addr      RAM word address (holds when wr_en=0)
//   wr_data      packed word (holds when wr_en=0)
//   busy         high while in RUN
//   frame_done   pulse coinciding with the final write of the frame
//   err_overrun  sticky, pix_valid seen outside RUN; cleared only by rst
module conv_pixel_packer #(
  parameter int IMG_W  = 638,
  parameter int IMG_H  = 478,
  parameter int ADDR_W = 17
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [3:0]        pix_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_overrun
);

  localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int LINE_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          slot;
  logic [COL_W-1:0]    col;
  logic [LINE_W-1:0]   line;
  logic [ADDR_W-1:0]   word_cnt;
  logic [11:0]         pack;
  logic [11:0]         pack_nxt;
  logic                accept;
  logic                drop;
  logic                col_last;
  logic                line_last;
  logic                word_done;

  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign line_last = (line == LINE_W'(IMG_H - 1));
  assign busy      = (state == S_RUN);

  // Next-state and accept/drop decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        drop = pix_valid;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        accept = pix_valid;
        if (pix_valid && col_last && line_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        drop      = pix_valid;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A word closes on its third nibble or on the last column of a line,
  // whichever comes first; slots not yet written are still zero.
  assign word_done = accept && ((slot == 2'd2) || col_last);

  always_comb begin
    pack_nxt = pack;
    case (slot)
      2'd0:    pack_nxt[11:8] = pix_in;
      2'd1:    pack_nxt[7:4]  = pix_in;
      default: pack_nxt[3:0]  = pix_in;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pack/count stage: accepting edge
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      slot        <= '0;
      col         <= '0;
      line        <= '0;
      word_cnt    <= '0;
      pack        <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (drop) err_overrun <= 1'b1;

      if (word_done) begin
        pack     <= '0;
        slot     <= '0;
        word_cnt <= word_cnt + 1'b1;
      end else if (accept) begin
        pack <= pack_nxt;
        slot <= slot + 2'd1;
      end

      if (accept) begin
        if (col_last) begin
          col  <= '0;
          line <= line_last ? '0 : line + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // DONE -> IDLE: next frame starts addressing from zero
      if (state == S_DONE) word_cnt <= '0;
    end
  end

  // Write stage: registered one cycle after the accepting edge
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= word_done;
      frame_done <= accept && col_last && line_last;
      if (word_done) begin
        wr_addr <= word_cnt;
        wr_data <= pack_nxt;
      end
    end
  end

endmodule

// File: tb/tb_conv_pixel_packer.sv
// Testbench for conv_pixel_packer (IMG_W=5, IMG_H=2). A driver issues
// pixels and pushes the expected RAM writes into a queue; a monitor pops
// and compares whenever the DUT strobes wr_en.
module tb_conv_pixel_packer;
  localparam int W   = 5;
  localparam int H   = 2;
  localparam int AW  = 8;
  localparam int WPL = (W + 2) / 3;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [3:0]    pix_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          err_overrun;

  conv_pixel_packer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_in      (pix_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_overrun (err_overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int addr;
    int data;
    bit last;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fd_seen  = 0;
  int   fd_exp   = 0;
  int   cur_word = 0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge pixel_clk) begin
    if (!rst) begin
      if (frame_done) fd_seen++;
      if (wr_en) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end else begin
          mon_e = q.pop_front();
          check("wr_addr", 32'(wr_addr), mon_e.addr);
          check("wr_data", 32'(wr_data), mon_e.data);
          check("frame_done", 32'(frame_done), 32'(mon_e.last));
          check("write_cycle", cyc, mon_e.due);
        end
      end else begin
        check("frame_done_no_write", 32'(frame_done), 0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          mon_e = q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_write actual none expected addr=%0h data=%0h", mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge pixel_clk);
      pix_valid = 1'b0;
      start     = 1'b0;
    end
  endtask

  // Reference model: pixel k of the frame sits at line k/W, column k%W;
  // its word is line*WPL + col/3 and its nibble is col%3 counted from the top.
  task automatic send_pix(input int k, input logic [3:0] p);
    int   col;
    int   line;
    exp_t e;
    col  = k % W;
    line = k / W;
    @(negedge pixel_clk);
    start     = 1'b0;
    pix_valid = 1'b1;
    pix_in    = p;
    cur_word  = cur_word | (int'(p) << (4 * (2 - col % 3)));
    if (col % 3 == 2 || col == W - 1) begin
      e.addr = line * WPL + col / 3;
      e.data = cur_word;
      e.last = (k == W * H - 1);
      e.due  = cyc + 1;
      q.push_back(e);
      cur_word = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge pixel_clk);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic run_frame(input bit fixed, input int gap_pct, input bit stray_start,
                           input bit stray_done);
    @(negedge pixel_clk);
    start     = 1'b1;
    pix_valid = 1'b0;
    cur_word  = 0;
    for (int k = 0; k < W * H; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct)
        idle_cycles($urandom_range(1, 3));
      if (stray_start && k == 3) begin
        @(negedge pixel_clk);
        start     = 1'b1;
        pix_valid = 1'b0;
      end
      send_pix(k, fixed ? 4'(k + 1) : 4'($urandom_range(15)));
      if (k == 2) check("busy_in_run", 32'(busy), 1);
    end
    if (stray_done) begin
      @(negedge pixel_clk);
      pix_valid = 1'b1;
      pix_in    = 4'hF;
    end
    idle_cycles(2);
    fd_exp++;
    drain();
    check("busy_after_frame", 32'(busy), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 4'h0;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b0;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err", 32'(err_overrun), 0);

    // Pixels 1..A back to back: 0x123, 0x450, 0x678, 0x9A0
    run_frame(1'b1, 0, 1'b0, 1'b0);
    check("err_clean", 32'(err_overrun), 0);

    // Same frame with gaps, then random data with gaps and a stray start
    run_frame(1'b1, 40, 1'b0, 1'b0);
    run_frame(1'b0, 40, 1'b1, 1'b0);
    run_frame(1'b0, 30, 1'b0, 1'b0);
    check("err_after_stray_start", 32'(err_overrun), 0);

    // Pixel arriving during DONE is dropped and flagged
    run_frame(1'b0, 0, 1'b0, 1'b1);
    check("err_from_done", 32'(err_overrun), 1);

    @(negedge pixel_clk);
    rst = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b0;
    check("err_cleared_by_rst", 32'(err_overrun), 0);

    // Pixel before start: dropped, sticky flag
    @(negedge pixel_clk);
    pix_valid = 1'b1;
    pix_in    = 4'h7;
    idle_cycles(3);
    check("err_from_idle", 32'(err_overrun), 1);
    run_frame(1'b0, 20, 1'b0, 1'b0);
    check("err_sticky", 32'(err_overrun), 1);

    // Abort mid-frame after three pixels of line 1
    @(negedge pixel_clk);
    start     = 1'b1;
    pix_valid = 1'b0;
    cur_word  = 0;
    for (int k = 0; k < W + 3; k++) send_pix(k, 4'($urandom_range(15)));
    idle_cycles(1);
    #1 rst = 1'b1;
    #1;
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_wr_addr", 32'(wr_addr), 0);
    check("abort_wr_data", 32'(wr_data), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_frame_done", 32'(frame_done), 0);
    check("abort_err", 32'(err_overrun), 0);
    check("abort_queue", q.size(), 0);
    q.delete();
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;

    // New frame after abort restarts at address 0
    run_frame(1'b1, 0, 1'b0, 1'b0);
    run_frame(1'b0, 50, 1'b0, 1'b0);

    idle_cycles(3);
    check("frame_done_count", fd_seen, fd_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
